exec_unit: RTL

Parametrised execute stage for the sequential Y86-64 CPU: selects ALU operands from icode, computes valE, owns the condition-code register and evaluates Cnd. Extends the single-cycle execute stage in three ways:
- configurable datapath width;
- new OPq functions: multiply (iterative, multi-cycle) and two shifts;
- a valid/ready handshake, so the sequential controller stalls until the result is ready.

Sits between decode (valA/valB/valC) and memory/write-back.

---
 rtl/exec_pkg.sv | 61 ++++++
 rtl/iter_multiplier.sv | 59 +++++
 rtl/exec_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the Y86-64 execute stage: instruction codes, ALU
// functions, condition codes, flag positions and the controller states.
package exec_pkg;

   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IBTN    = 4'hD;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_XOR = 3'd3,
      ALU_MUL = 3'd4,
      ALU_SHL = 3'd5,
      ALU_SAR = 3'd6
   } alu_fun_t;

   localparam logic [3:0] COND_ALWAYS = 4'd0;
   localparam logic [3:0] COND_LE     = 4'd1;
   localparam logic [3:0] COND_L      = 4'd2;
   localparam logic [3:0] COND_E      = 4'd3;
   localparam logic [3:0] COND_NE     = 4'd4;
   localparam logic [3:0] COND_GE     = 4'd5;
   localparam logic [3:0] COND_G      = 4'd6;
   localparam logic [3:0] COND_BTN    = 4'd7;

   localparam int CC_BF = 3;
   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;
   localparam logic [3:0] CC_RESET = 4'b0100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MUL  = 2'd2
   } state_t;

   function automatic logic eval_cond(input logic [3:0] flags, input logic [3:0] fn);
      logic lt;
      lt = flags[CC_SF] ^ flags[CC_OF];
      case (fn)
         COND_ALWAYS: return 1'b1;
         COND_LE:     return lt | flags[CC_ZF];
         COND_L:      return lt;
         COND_E:      return flags[CC_ZF];
         COND_NE:     return ~flags[CC_ZF];
         COND_GE:     return ~lt;
         COND_G:      return ~lt & ~flags[CC_ZF];
         COND_BTN:    return flags[CC_BF];
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/iter_multiplier.sv
// Shift-add multiplier: one multiplier bit per cycle, WIDTH cycles after start,
// then a one-cycle done pulse with the low WIDTH bits of a*b on product.
module iter_multiplier #(
   parameter int WIDTH = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] mcand_reg;
   logic [WIDTH-1:0] mplier_reg;
   logic [WIDTH-1:0] acc_reg;
   logic [CW-1:0]    cnt_reg;
   logic             busy_reg;
   logic             done_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (start) begin
            mcand_reg  <= a;
            mplier_reg <= b;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
         end else if (busy_reg) begin
            if (mplier_reg[0])
               acc_reg <= acc_reg + mcand_reg;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (cnt_reg == CW'(WIDTH - 1)) begin
               busy_reg <= 1'b0;
               done_reg <= 1'b1;
            end
         end
      end
   end

   assign busy    = busy_reg;
   assign done    = done_reg;
   assign product = acc_reg;

endmodule

// File: rtl/exec_unit.sv
// Y86-64 execute stage with valid/ready handshake: operand select, ALU,
// optional iterative multiply, condition-code register and Cnd evaluation.
module exec_unit
   import exec_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       icode,
   input  logic [3:0]       ifun,
   input  logic [WIDTH-1:0] valA,
   input  logic [WIDTH-1:0] valB,
   input  logic [WIDTH-1:0] valC,
   input  logic             button,
   output logic             out_valid,
   output logic [WIDTH-1:0] valE,
   output logic             Cnd,
   output logic [3:0]       cc
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MINUS_8 = {{(WIDTH-4){1'b1}}, 4'b1000};

   state_t           state_reg;
   logic [WIDTH-1:0] alu_a_reg, alu_b_reg;
   alu_fun_t         alu_fun_reg;
   logic             cc_we_reg, is_btn_reg, btn_reg, cnd_reg;
   logic             out_valid_reg, cnd_out_reg;
   logic [WIDTH-1:0] val_e_reg;
   logic [3:0]       cc_reg, cc_pend_reg;
   logic             cc_pend_we_reg;

   logic [WIDTH-1:0] alu_a_sel, alu_b_sel;
   alu_fun_t         alu_fun_sel;
   logic             accept, mul_start;
   logic             mul_busy, mul_done;
   logic [WIDTH-1:0] mul_product;
   logic [WIDTH-1:0] alu_res;
   logic             alu_of;
   logic [3:0]       flags_next;

   assign in_ready = (state_reg == S_IDLE);
   assign accept   = in_valid && in_ready;

   always_comb begin
      alu_a_sel = WIDTH'(8);
      case (icode)
         IRRMOVQ, IOPQ:             alu_a_sel = valA;
         IIRMOVQ, IRMMOVQ, IMRMOVQ: alu_a_sel = valC;
         ICALL, IPUSHQ:             alu_a_sel = MINUS_8;
         default:                   alu_a_sel = WIDTH'(8);
      endcase
      alu_b_sel = (icode == IRRMOVQ || icode == IIRMOVQ) ? '0 : valB;
      alu_fun_sel = ALU_ADD;
      if (icode == IOPQ && ifun <= 4'd6)
         alu_fun_sel = alu_fun_t'(ifun[2:0]);
      if (alu_fun_sel == ALU_MUL && !MUL_EN)
         alu_fun_sel = ALU_ADD;
   end

   assign mul_start = accept && (alu_fun_sel == ALU_MUL);

   generate
      if (MUL_EN) begin : g_mul
         iter_multiplier #(.WIDTH(WIDTH)) u_mul (
            .clock   (clock),
            .reset   (reset),
            .start   (mul_start),
            .a       (alu_a_sel),
            .b       (alu_b_sel),
            .busy    (mul_busy),
            .done    (mul_done),
            .product (mul_product)
         );
      end else begin : g_no_mul
         logic unused_mul;
         assign unused_mul  = mul_start;
         assign mul_busy    = 1'b0;
         assign mul_done    = 1'b0;
         assign mul_product = '0;
      end
   endgenerate

   // In S_MUL the latched function is ALU_MUL, so the same flag path serves both.
   always_comb begin
      alu_res = alu_b_reg + alu_a_reg;
      alu_of  = 1'b0;
      case (alu_fun_reg)
         ALU_ADD: begin
            alu_res = alu_b_reg + alu_a_reg;
            alu_of  = (alu_a_reg[WIDTH-1] == alu_b_reg[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != alu_a_reg[WIDTH-1]);
         end
         ALU_SUB: begin
            alu_res = alu_b_reg - alu_a_reg;
            alu_of  = (alu_a_reg[WIDTH-1] != alu_b_reg[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != alu_b_reg[WIDTH-1]);
         end
         ALU_AND: alu_res = alu_b_reg & alu_a_reg;
         ALU_XOR: alu_res = alu_b_reg ^ alu_a_reg;
         ALU_MUL: alu_res = mul_product;
         ALU_SHL: alu_res = alu_b_reg << alu_a_reg[SHW-1:0];
         ALU_SAR: alu_res = $signed(alu_b_reg) >>> alu_a_reg[SHW-1:0];
         default: alu_res = alu_b_reg + alu_a_reg;
      endcase
      flags_next = {is_btn_reg ? btn_reg : cc_reg[CC_BF],
                    alu_res == '0, alu_res[WIDTH-1], alu_of};
   end

   // New flags become visible on cc one cycle after the out_valid pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= S_IDLE;
         alu_a_reg      <= '0;
         alu_b_reg      <= '0;
         alu_fun_reg    <= ALU_ADD;
         cc_we_reg      <= 1'b0;
         is_btn_reg     <= 1'b0;
         btn_reg        <= 1'b0;
         cnd_reg        <= 1'b0;
         out_valid_reg  <= 1'b0;
         val_e_reg      <= '0;
         cnd_out_reg    <= 1'b0;
         cc_reg         <= CC_RESET;
         cc_pend_reg    <= CC_RESET;
         cc_pend_we_reg <= 1'b0;
      end else begin
         out_valid_reg <= 1'b0;
         if (out_valid_reg && cc_pend_we_reg)
            cc_reg <= cc_pend_reg;
         case (state_reg)
            S_IDLE: begin
               if (in_valid) begin
                  alu_a_reg   <= alu_a_sel;
                  alu_b_reg   <= alu_b_sel;
                  alu_fun_reg <= alu_fun_sel;
                  cc_we_reg   <= (icode == IOPQ) || (icode == IBTN);
                  is_btn_reg  <= (icode == IBTN);
                  btn_reg     <= button;
                  cnd_reg     <= eval_cond(cc_reg, ifun);
                  state_reg   <= (alu_fun_sel == ALU_MUL) ? S_MUL : S_EXEC;
               end
            end
            S_EXEC: begin
               out_valid_reg  <= 1'b1;
               val_e_reg      <= alu_res;
               cnd_out_reg    <= cnd_reg;
               cc_pend_reg    <= flags_next;
               cc_pend_we_reg <= cc_we_reg;
               state_reg      <= S_IDLE;
            end
            S_MUL: begin
               if (mul_done && !mul_busy) begin
                  out_valid_reg  <= 1'b1;
                  val_e_reg      <= alu_res;
                  cnd_out_reg    <= cnd_reg;
                  cc_pend_reg    <= flags_next;
                  cc_pend_we_reg <= cc_we_reg;
                  state_reg      <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign out_valid = out_valid_reg;
   assign valE      = val_e_reg;
   assign Cnd       = cnd_out_reg;
   assign cc        = cc_reg;

endmodule
